// File: rtl/uart_tx_pkg.sv
// rtl/uart_tx_pkg.sv - shared state encoding and line constants for the UART transmitter
//
// Purpose: state codes for the frame FSM, parity-type and line-level constants,
//          and a small parity helper used by the top level.
// Ports:   none (package).

package uart_tx_pkg;

  // Frame FSM state codes
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  localparam logic PAR_EVEN  = 1'b0;
  localparam logic PAR_ODD   = 1'b1;
  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  // Turns the XOR-reduction of the payload into the bit placed in the parity slot.
  function automatic logic parity_slot(input logic data_xor, input logic par_typ);
    return (par_typ == PAR_ODD) ? ~data_xor : data_xor;
  endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// rtl/uart_tx_serializer.sv - load/shift register and bit counter for the TX data phase
//
// Purpose: holds the word being sent, presents the next data bit on ser_bit and
//          flags the last data bit of the frame on ser_done.
// Ports:
//   clk        in   bit clock
//   rst_n      in   synchronous active-low reset
//   load       in   capture load_data, clear counter
//   shift      in   right-shift the register by one bit
//   count      in   advance the bit counter
//   load_data  in   word to capture on load
//   ser_bit    out  LSB of the shift register
//   ser_done   out  counter has reached DATA_WIDTH-1

module uart_tx_serializer
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic                  shift,
  input  logic                  count,
  input  logic [DATA_WIDTH-1:0] load_data,
  output logic                  ser_bit,
  output logic                  ser_done
);

  localparam int CNT_W = $clog2(DATA_WIDTH);

  logic [DATA_WIDTH-1:0] shift_reg;
  logic [CNT_W-1:0]      bit_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
    end else if (load) begin
      shift_reg <= load_data;
      bit_cnt   <= '0;
    end else begin
      if (shift) shift_reg <= shift_reg >> 1;
      if (count) bit_cnt <= bit_cnt + 1'b1;
    end
  end

  assign ser_bit  = shift_reg[0];
  assign ser_done = (bit_cnt == CNT_W'(DATA_WIDTH - 1));

endmodule

// File: rtl/uart_tx_frame.sv
// rtl/uart_tx_frame.sv - UART transmitter, one frame bit per clock
//
// Purpose: accepts a parallel word on a valid/busy handshake and drives
//          start, DATA_WIDTH data bits LSB-first, optional parity, stop.
//          Build option UART_TX_PARITY_EN adds the per-frame parity slot;
//          without it par_en/par_typ are ignored.
// Ports:
//   CLK         in   TX bit clock
//   RST_n       in   synchronous active-low reset
//   p_data      in   word to send
//   data_valid  in   word valid; taken on an edge where busy is low
//   par_en      in   insert parity bit (parity builds only)
//   par_typ     in   0 even, 1 odd parity
//   tx_out      out  registered serial line, idle high
//   busy        out  high from start bit through last data/parity bit

module uart_tx_frame
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST_n,
  input  logic [DATA_WIDTH-1:0] p_data,
  input  logic                  data_valid,
  input  logic                  par_en,
  input  logic                  par_typ,
  output logic                  tx_out,
  output logic                  busy
);

  logic [2:0] state;
  logic       accept;
  logic       ser_bit;
  logic       ser_done;
  logic       ser_shift;
  logic       ser_count;

  // busy is low only in IDLE and STOP, so this covers both the idle accept
  // and the back-to-back accept out of STOP.
  assign accept = data_valid && !busy;

  // START presents bit 0 without advancing the counter, so the counter
  // equals the index of the bit currently on the line during DATA.
  assign ser_shift = (state == ST_START) || ((state == ST_DATA) && !ser_done);
  assign ser_count = (state == ST_DATA) && !ser_done;

  uart_tx_serializer #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_serializer (
    .clk       (CLK),
    .rst_n     (RST_n),
    .load      (accept),
    .shift     (ser_shift),
    .count     (ser_count),
    .load_data (p_data),
    .ser_bit   (ser_bit),
    .ser_done  (ser_done)
  );

`ifdef UART_TX_PARITY_EN
  // Copy of the accepted word and its parity settings; the shift register
  // is consumed during DATA, so parity is taken from this copy.
  logic [DATA_WIDTH-1:0] data_q;
  logic                  par_en_q;
  logic                  par_typ_q;
  logic                  par_bit;

  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      data_q    <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= PAR_EVEN;
    end else if (accept) begin
      data_q    <= p_data;
      par_en_q  <= par_en;
      par_typ_q <= par_typ;
    end
  end

  assign par_bit = parity_slot(^data_q, par_typ_q);
`else
  logic unused_cfg;
  assign unused_cfg = par_en ^ par_typ;
`endif

  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      state  <= ST_IDLE;
      tx_out <= LINE_IDLE;
      busy   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_STOP: begin
          if (accept) begin
            state  <= ST_START;
            tx_out <= START_BIT;
            busy   <= 1'b1;
          end else begin
            state  <= ST_IDLE;
            tx_out <= LINE_IDLE;
            busy   <= 1'b0;
          end
        end
        ST_START: begin
          state  <= ST_DATA;
          tx_out <= ser_bit;
        end
        ST_DATA: begin
          if (!ser_done) begin
            tx_out <= ser_bit;
`ifdef UART_TX_PARITY_EN
          end else if (par_en_q) begin
            state  <= ST_PARITY;
            tx_out <= par_bit;
`endif
          end else begin
            state  <= ST_STOP;
            tx_out <= STOP_BIT;
            busy   <= 1'b0;
          end
        end
`ifdef UART_TX_PARITY_EN
        ST_PARITY: begin
          state  <= ST_STOP;
          tx_out <= STOP_BIT;
          busy   <= 1'b0;
        end
`endif
        default: begin
          state  <= ST_IDLE;
          tx_out <= LINE_IDLE;
          busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// tb/tb_uart_tx_frame.sv - self-checking bench for uart_tx_frame

module tb_uart_tx_frame;

  logic       CLK;
  logic       RST_n;
  logic [7:0] p_data;
  logic       data_valid;
  logic       par_en;
  logic       par_typ;
  logic       tx_out;
  logic       busy;

  int checks = 0;
  int errors = 0;

  // Expected {tx_out, busy} per clock, in line order
  logic [1:0] exp_q[$];

  uart_tx_frame #(.DATA_WIDTH(8)) dut (
    .CLK        (CLK),
    .RST_n      (RST_n),
    .p_data     (p_data),
    .data_valid (data_valid),
    .par_en     (par_en),
    .par_typ    (par_typ),
    .tx_out     (tx_out),
    .busy       (busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic push_frame(input logic [7:0] d, input logic pe, input logic pt);
    logic p;
    p = pt;
    exp_q.push_back(2'b01);
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back({d[i], 1'b1});
      p = p ^ d[i];
    end
`ifdef UART_TX_PARITY_EN
    if (pe) exp_q.push_back({p, 1'b1});
`else
    if (pe && !pe) exp_q.push_back({p, 1'b1});
`endif
    exp_q.push_back(2'b10);
  endtask

  task automatic test_reset();
    RST_n = 1'b0;
    data_valid = 1'b0;
    p_data = 8'h00;
    par_en = 1'b0;
    par_typ = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      checks++;
      if ({tx_out, busy} !== 2'b10) begin
        errors++;
        $display("FAIL reset cycle %0d: tx_out/busy=%b required 10", i, {tx_out, busy});
      end
    end
    RST_n = 1'b1;
    @(negedge CLK);
    checks++;
    if ({tx_out, busy} !== 2'b10) begin
      errors++;
      $display("FAIL idle_after_reset: tx_out/busy=%b required 10", {tx_out, busy});
    end
  endtask

  task automatic test_plain_frame();
    int n;
    logic [1:0] exp;
    p_data = 8'hA5;
    par_en = 1'b0;
    par_typ = 1'b0;
    data_valid = 1'b1;
    push_frame(8'hA5, 1'b0, 1'b0);
    exp_q.push_back(2'b10);
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      exp = exp_q.pop_front();
      checks++;
      if ({tx_out, busy} !== exp) begin
        errors++;
        $display("FAIL plain_frame cycle %0d: tx_out/busy=%b required %b", i, {tx_out, busy}, exp);
      end
      if (i == 0) data_valid = 1'b0;
    end
  endtask

  task automatic test_parity();
    int n;
    logic [1:0] exp;
    for (int t = 0; t < 2; t++) begin
      p_data = 8'hA5;
      par_en = 1'b1;
      par_typ = t[0];
      data_valid = 1'b1;
      push_frame(8'hA5, 1'b1, t[0]);
      exp_q.push_back(2'b10);
      n = exp_q.size();
      for (int i = 0; i < n; i++) begin
        @(negedge CLK);
        exp = exp_q.pop_front();
        checks++;
        if ({tx_out, busy} !== exp) begin
          errors++;
          $display("FAIL parity typ=%0d cycle %0d: tx_out/busy=%b required %b", t, i, {tx_out, busy}, exp);
        end
        if (i == 0) begin
          data_valid = 1'b0;
          par_typ = ~par_typ;
        end
      end
    end
    par_en = 1'b0;
    par_typ = 1'b0;
  endtask

  task automatic test_back_to_back();
    int n;
    logic [1:0] exp;
    p_data = 8'h00;
    data_valid = 1'b1;
    push_frame(8'h00, 1'b0, 1'b0);
    push_frame(8'hFF, 1'b0, 1'b0);
    exp_q.push_back(2'b10);
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      exp = exp_q.pop_front();
      checks++;
      if ({tx_out, busy} !== exp) begin
        errors++;
        $display("FAIL back_to_back cycle %0d: tx_out/busy=%b required %b", i, {tx_out, busy}, exp);
      end
      if (i == 0) p_data = 8'hFF;
      if (i == 10) data_valid = 1'b0;
    end
  endtask

  task automatic test_ignore_busy();
    int n;
    logic [1:0] exp;
    p_data = 8'h3C;
    data_valid = 1'b1;
    push_frame(8'h3C, 1'b0, 1'b0);
    exp_q.push_back(2'b10);
    exp_q.push_back(2'b10);
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      exp = exp_q.pop_front();
      checks++;
      if ({tx_out, busy} !== exp) begin
        errors++;
        $display("FAIL ignore_busy cycle %0d: tx_out/busy=%b required %b", i, {tx_out, busy}, exp);
      end
      if (i == 0) data_valid = 1'b0;
      if (i == 3) begin
        data_valid = 1'b1;
        p_data = 8'hC3;
        par_en = 1'b1;
        par_typ = 1'b1;
      end
      if (i == 4) begin
        data_valid = 1'b0;
        par_en = 1'b0;
        par_typ = 1'b0;
      end
    end
  endtask

  task automatic test_mid_reset();
    int n;
    logic [1:0] exp;
    p_data = 8'h5A;
    data_valid = 1'b1;
    push_frame(8'h5A, 1'b0, 1'b0);
    // start, bit0..bit3, then reset truncates the frame
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      exp = exp_q.pop_front();
      checks++;
      if ({tx_out, busy} !== exp) begin
        errors++;
        $display("FAIL mid_reset pre cycle %0d: tx_out/busy=%b required %b", i, {tx_out, busy}, exp);
      end
      if (i == 0) data_valid = 1'b0;
    end
    exp_q.delete();
    // reset together with a valid word: the word must be dropped
    RST_n = 1'b0;
    data_valid = 1'b1;
    p_data = 8'hFF;
    exp_q.push_back(2'b10);
    exp_q.push_back(2'b10);
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      exp = exp_q.pop_front();
      checks++;
      if ({tx_out, busy} !== exp) begin
        errors++;
        $display("FAIL mid_reset hold cycle %0d: tx_out/busy=%b required %b", i, {tx_out, busy}, exp);
      end
      if (i == 0) data_valid = 1'b0;
    end
    RST_n = 1'b1;
    @(negedge CLK);
    checks++;
    if ({tx_out, busy} !== 2'b10) begin
      errors++;
      $display("FAIL mid_reset release: tx_out/busy=%b required 10", {tx_out, busy});
    end
    p_data = 8'h5A;
    data_valid = 1'b1;
    push_frame(8'h5A, 1'b0, 1'b0);
    exp_q.push_back(2'b10);
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      exp = exp_q.pop_front();
      checks++;
      if ({tx_out, busy} !== exp) begin
        errors++;
        $display("FAIL mid_reset resend cycle %0d: tx_out/busy=%b required %b", i, {tx_out, busy}, exp);
      end
      if (i == 0) data_valid = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_plain_frame();
    test_parity();
    test_back_to_back();
    test_ignore_busy();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
